// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: DIFF = A - B - BIN, one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUBTRACTOR_SIGNED_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT,
    output logic             OVF
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sa, r_sb, r_sd, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_bout;

    logic w_a, w_b, w_d, w_bo, w_last, w_accept, w_run;

    // one full-subtractor cell, time-shared over every bit position
    assign w_a      = r_sa[0];
    assign w_b      = r_sb[0];
    assign w_d      = w_a ^ w_b ^ r_br;
    assign w_bo     = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_run    = (r_state == RUN);
    assign w_last   = w_run && (r_cnt == CW'(WIDTH-1));
    assign w_accept = START && (r_state != RUN);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (START) w_next = RUN;
            RUN:     if (w_last) w_next = FIN;
            FIN:     w_next = START ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sd   <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= A;
            r_sb  <= B;
            r_br  <= BIN;
            r_cnt <= '0;
        end else if (w_run) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_sd  <= {w_d, r_sd[WIDTH-1:1]};
            r_br  <= w_bo;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff <= {w_d, r_sd[WIDTH-1:1]};
                r_bout <= w_bo;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
    logic r_ovf;

    // on the last step w_a/w_b are the operand sign bits and w_d the result sign
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)      r_ovf <= 1'b0;
        else if (w_last) r_ovf <= (w_a ^ w_b) & (w_a ^ w_d);
    end

    assign OVF = r_ovf;
`else
    assign OVF = 1'b0;
`endif

    assign BUSY = w_run;
    assign DONE = (r_state == FIN);
    assign DIFF = r_diff;
    assign BOUT = r_bout;
endmodule
